// File: rtl/apb_master.sv
// APB4 master stage: turns a single-cycle request from the AXI4-lite front-end
// into an APB SETUP/ACCESS transfer. It handles slave decode, PREADY wait states,
// a wait-state timeout and decode errors, and returns read data, an error flag
// and a one-cycle done pulse.
module apb_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 3,
  parameter int SEL_BITS   = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                             ACLK,
  input  logic                             ARESETn,
  input  logic                             transfer,
  input  logic                             read,
  input  logic                             write,
  input  logic [ADDR_WIDTH-1:0]            apb_waddr,
  input  logic [ADDR_WIDTH-1:0]            apb_raddr,
  input  logic [DATA_WIDTH-1:0]            apb_wdata,
  input  logic [DATA_WIDTH/8-1:0]          apb_wstrb,
  output logic [DATA_WIDTH-1:0]            apb_rdata,
  output logic                             err_flag,
  output logic                             apb_done,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [DATA_WIDTH/8-1:0]          PSTRB,
  output logic [2:0]                       PPROT,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SETUP  = 2'b01,
    S_ACCESS = 2'b10,
    S_DECERR = 2'b11
  } state_e;

  state_e                  state_q,   state_d;
  logic [NUM_SLAVES-1:0]   psel_q,    psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q,  pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q,   paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q,  pwdata_d;
  logic [STRB_W-1:0]       pstrb_q,   pstrb_d;
  logic [DATA_WIDTH-1:0]   rdata_q,   rdata_d;
  logic                    err_q,     err_d;
  logic                    done_q,    done_d;
  logic [CNT_W-1:0]        cnt_q,     cnt_d;

  logic                    req_s;
  logic [ADDR_WIDTH-1:0]   req_addr_s;
  logic [SEL_BITS-1:0]     idx_s;
  logic [NUM_SLAVES-1:0]   sel_oh_s;
  logic                    sel_valid_s;
  logic                    ready_s;
  logic                    slverr_s;
  logic [DATA_WIDTH-1:0]   prdata_sel_s;

  // Request qualification and address choice; write wins when both are high.
  assign req_s       = transfer & (write | read);
  assign req_addr_s  = write ? apb_waddr : apb_raddr;
  assign idx_s       = req_addr_s[ADDR_WIDTH-1 -: SEL_BITS];
  assign sel_valid_s = |sel_oh_s;

  // The latched one-hot PSEL picks the active slave's ready/error lines, so an
  // out-of-range index never reaches a per-slave array.
  assign ready_s  = |(PREADY & psel_q);
  assign slverr_s = |(PSLVERR & psel_q);

  // Decode the slave index to one-hot; indices at or above NUM_SLAVES give all zeros.
  always_comb begin
    sel_oh_s = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel_oh_s[i] = (idx_s == SEL_BITS'(i));
    end
  end

  // AND-OR mux of the selected slave's read data slice.
  always_comb begin
    prdata_sel_s = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      prdata_sel_s = prdata_sel_s | (PRDATA[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{psel_q[i]}});
    end
  end

  // Next-state and next-output logic for the SETUP/ACCESS sequencer.
  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          paddr_d  = req_addr_s;
          pwrite_d = write;
          if (write) begin
            pwdata_d = apb_wdata;
            pstrb_d  = apb_wstrb;
          end else begin
            pstrb_d  = '0;
          end
          err_d   = 1'b0;
          rdata_d = '0;
          if (sel_valid_s) begin
            psel_d  = sel_oh_s;
            state_d = S_SETUP;
          end else begin
            psel_d  = '0;
            state_d = S_DECERR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_ACCESS;
      end

      S_ACCESS: begin
        if (ready_s) begin
          err_d     = slverr_s;
          rdata_d   = pwrite_q ? '0 : prdata_sel_s;
          done_d    = 1'b1;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // This is the TIMEOUT-th consecutive low sample: abort the transfer.
          err_d     = 1'b1;
          rdata_d   = '0;
          done_d    = 1'b1;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_DECERR: begin
        err_d   = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        psel_d    = '0;
        penable_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset returns to IDLE with every output zero.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= S_IDLE;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign PPROT     = 3'b000;
  assign apb_rdata = rdata_q;
  assign err_flag  = err_q;
  assign apb_done  = done_q;

endmodule

// File: doc/apb_master.md
# apb_master

APB4 master stage that sits directly downstream of the AXI4-lite slave front-end. It accepts the single-cycle `transfer`/`read`/`write` request with the latched address, data and strobe. It decodes the target slave and runs the APB SETUP/ACCESS protocol, including PREADY wait states, a wait-state timeout and decode errors. It returns `apb_rdata`, `err_flag` and a one-cycle `apb_done` to the front-end.

## Interface
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width; strobe width is DATA_WIDTH/8.
- `NUM_SLAVES`, 3: number of APB slaves (1..2^SEL_BITS).
- `SEL_BITS`, 2: slave index = address[ADDR_WIDTH-1 -: SEL_BITS].
- `TIMEOUT`, 16: maximum ACCESS cycles with PREADY low before abort (≥2).

Ports:
- `ACLK`  in  1  clock; all logic on rising edge.
- `ARESETn`  in  1  reset; asynchronous assert, active-low.
- `transfer`, `read`, `write`  in  1 each  request pulse and direction from the front-end.
- `apb_waddr`, `apb_raddr`  in  ADDR_WIDTH  write and read address.
- `apb_wdata`  in  DATA_WIDTH  write data.
- `apb_wstrb`  in  DATA_WIDTH/8  write strobe.
- `apb_rdata`  out  DATA_WIDTH  captured read data.
- `err_flag`  out  1  error for the last transfer.
- `apb_done`  out  1  one-cycle completion pulse.
- `PSEL`  out  NUM_SLAVES  one-hot slave select.
- `PENABLE`, `PWRITE`  out  1 each  APB enable and direction.
- `PADDR`  out  ADDR_WIDTH  bus address.
- `PWDATA`  out  DATA_WIDTH  bus write data.
- `PSTRB`  out  DATA_WIDTH/8  bus strobe.
- `PPROT`  out  3  protection type; constant 3'b000.
- `PRDATA`  in  NUM_SLAVES*DATA_WIDTH  per-slave read data; slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `PREADY`, `PSLVERR`  in  NUM_SLAVES each  per-slave ready and error.

## Operation
States are IDLE, SETUP, ACCESS and DECERR. All outputs are registered.

- **IDLE**
  - A request is `transfer`=1 with `write` or `read` high.
  - If both are high, write wins. `transfer` with neither high is ignored.
  - On a request:
    - Latch PADDR (apb_waddr for a write, apb_raddr for a read), PWRITE and the slave index.
    - For a write, latch PWDATA=apb_wdata and PSTRB=apb_wstrb. For a read, PSTRB=0 and PWDATA holds its last value.
    - Clear err_flag and apb_rdata to 0.
    - If index < NUM_SLAVES: assert PSEL[index] and go to SETUP. Otherwise go to DECERR.
- **SETUP** (one cycle): PSEL held, PENABLE=0. Next state is ACCESS with PENABLE=1 and the wait counter cleared.
- **ACCESS**: PREADY[index] is sampled each edge.
  - If high:
    - Capture PSLVERR[index] into err_flag.
    - For reads, capture PRDATA slice `index` into apb_rdata. For writes, apb_rdata stays 0.
    - Pulse apb_done, drop PSEL and PENABLE, and go to IDLE.
  - If low: increment the counter. When the TIMEOUT-th consecutive low cycle is sampled, abort:
    - err_flag=1, apb_rdata=0, pulse apb_done, drop PSEL and PENABLE, go to IDLE.
- **DECERR** (one cycle): no PSEL asserted. err_flag=1, pulse apb_done, go to IDLE.
- **Requests while not IDLE** are ignored (the front-end never issues them).
- **Held results**: err_flag and apb_rdata hold their value until the next accepted request, because the front-end samples them after apb_done.
- **Bus stability**: PADDR, PWRITE, PWDATA and PSTRB stay stable from SETUP through the end of ACCESS.

## Timing
- Reset value of every output is 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, apb_rdata, err_flag, apb_done.
- Assertion of ARESETn low at any time, including mid-transfer, forces IDLE and zeroes all outputs immediately; the in-flight transfer produces no apb_done.
- Request sampled at edge E0:
  - PSEL high after E0.
  - PENABLE high after E1.
  - With zero wait states, PREADY is sampled high at E2; apb_done, err_flag and apb_rdata are valid after E2, and PSEL and PENABLE are low after E2.
- Each PREADY-low cycle adds one cycle of latency.
- Timeout: apb_done follows the edge at which the TIMEOUT-th PREADY-low cycle is sampled, i.e. after E(1+TIMEOUT).
- Decode error: apb_done after E1; no APB bus activity.
- apb_done is high for exactly one cycle per accepted request.
- A new request can be accepted on the edge after apb_done falls, or later.

## Test plan
- **Reset**: hold ARESETn=0, then release → all outputs 0, state IDLE; pulse transfer with read=0 and write=0 → no bus activity.
- **Write, zero waits**: apb_waddr=32'h0000_0010, wdata=32'hDEAD_BEEF, wstrb=4'hF, PREADY=1 → PSEL=3'b001, PWRITE=1, PENABLE one cycle after PSEL; apb_done pulses 3 edges after the request; err_flag=0.
- **Read from slave 2 with 3 waits**: apb_raddr=32'h8000_0004, PRDATA slice 2 = 32'h1234_5678, PREADY low for 3 cycles → PSEL=3'b100, PSTRB=0; apb_rdata=32'h1234_5678 at apb_done, which arrives 3 cycles later than the zero-wait case.
- **Slave error on write**: PSLVERR=1 together with PREADY=1 → err_flag=1 held until the next request; apb_done pulses once.
- **Decode error**: address 32'hC000_0000 (index 3 ≥ NUM_SLAVES) → PSEL stays 0; err_flag=1; apb_done 2 edges after the request.
- **Timeout and reset mid-ACCESS**:
  - PREADY held low → abort after 16 low cycles with err_flag=1 and apb_rdata=0.
  - Repeat with ARESETn low mid-ACCESS → outputs zero immediately and no apb_done.
